// File: rtl/mips_id_regfile_sb.sv
// mips_id_regfile_sb: ID-stage register file with two writeback ports and a
// per-register pending-write scoreboard. Register 0 is hardwired to zero and
// indices >= NREG read as zero and ignore writes/issues.
// Optional feature: define MIPS_RF_BYPASS_EN to forward same-cycle writeback
// data (and clear the busy flag) onto matching read ports.

// One architectural register plus its pending bit.
module mips_id_regfile_cell #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int IDX = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb0_en,
    input  logic [AW-1:0] wb0_idx,
    input  logic [DW-1:0] wb0_dat,
    input  logic          wb1_en,
    input  logic [AW-1:0] wb1_idx,
    input  logic [DW-1:0] wb1_dat,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_idx,
    input  logic          flush,
    output logic [DW-1:0] q,
    output logic          pend
);
    localparam logic [AW-1:0] MY_IDX = AW'(IDX);

    logic hit0, hit1, hit_iss;

    assign hit0    = wb0_en && (wb0_idx == MY_IDX);
    assign hit1    = wb1_en && (wb1_idx == MY_IDX);
    assign hit_iss = iss_en && (iss_idx == MY_IDX);

    // Data: wb1 wins when both ports target this register; flush does not block writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (hit1)
            q <= wb1_dat;
        else if (hit0)
            q <= wb0_dat;
    end

    // Pending: a new producer beats flush, flush beats the writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= 1'b0;
        else if (hit_iss)
            pend <= 1'b1;
        else if (flush)
            pend <= 1'b0;
        else if (hit0 || hit1)
            pend <= 1'b0;
    end
endmodule

// One combinational read port over the stored state.
module mips_id_regfile_rd #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic [AW-1:0]            idx,
    input  logic [NREG-1:0][DW-1:0]  regs_q,
    input  logic [NREG-1:0]          pend_q,
`ifdef MIPS_RF_BYPASS_EN
    input  logic                     wb0_en,
    input  logic [AW-1:0]            wb0_idx,
    input  logic [DW-1:0]            wb0_dat,
    input  logic                     wb1_en,
    input  logic [AW-1:0]            wb1_idx,
    input  logic [DW-1:0]            wb1_dat,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_idx,
`endif
    output logic [DW-1:0]            dat,
    output logic                     busy
);
    logic [DW-1:0] st_dat;
    logic          st_busy;

    // Stored-state lookup; indices with no matching entry (>= NREG) fall through to zero.
    always_comb begin
        st_dat  = '0;
        st_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == AW'(i)) begin
                st_dat  = regs_q[i];
                st_busy = pend_q[i];
            end
        end
    end

`ifdef MIPS_RF_BYPASS_EN
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    logic in_rng, hit0, hit1, hit_iss;

    assign in_rng  = (idx != '0) && ({1'b0, idx} < NREG_L);
    assign hit0    = wb0_en && (wb0_idx == idx);
    assign hit1    = wb1_en && (wb1_idx == idx);
    assign hit_iss = iss_en && (iss_idx == idx);

    // Forward in-flight writeback; busy drops unless a new producer targets the same reg.
    always_comb begin
        dat  = st_dat;
        busy = st_busy;
        if (in_rng && (hit0 || hit1)) begin
            dat  = hit1 ? wb1_dat : wb0_dat;
            busy = hit_iss ? st_busy : 1'b0;
        end
    end
`else
    assign dat  = st_dat;
    assign busy = st_busy;
`endif
endmodule

// Top: register array, read ports and aggregate busy.
module mips_id_regfile_sb #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32,   // must not exceed 2**AW
    parameter int NRD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_idx,
    output logic [NRD*DW-1:0] rd_dat,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wb0_en,
    input  logic [AW-1:0]     wb0_idx,
    input  logic [DW-1:0]     wb0_dat,
    input  logic              wb1_en,
    input  logic [AW-1:0]     wb1_idx,
    input  logic [DW-1:0]     wb1_dat,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_idx,
    input  logic              flush,
    output logic              any_busy
);
    logic [NREG-1:0][DW-1:0] regs_q;
    logic [NREG-1:0]         pend_q;

    // Register 0 has no storage: it always reads zero and is never pending.
    assign regs_q[0] = '0;
    assign pend_q[0] = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            mips_id_regfile_cell #(.DW(DW), .AW(AW), .IDX(i)) u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .wb0_en  (wb0_en),
                .wb0_idx (wb0_idx),
                .wb0_dat (wb0_dat),
                .wb1_en  (wb1_en),
                .wb1_idx (wb1_idx),
                .wb1_dat (wb1_dat),
                .iss_en  (iss_en),
                .iss_idx (iss_idx),
                .flush   (flush),
                .q       (regs_q[i]),
                .pend    (pend_q[i])
            );
        end

        for (genvar k = 0; k < NRD; k++) begin : g_rd
            mips_id_regfile_rd #(.DW(DW), .AW(AW), .NREG(NREG)) u_rd (
                .idx     (rd_idx[k*AW +: AW]),
                .regs_q  (regs_q),
                .pend_q  (pend_q),
`ifdef MIPS_RF_BYPASS_EN
                .wb0_en  (wb0_en),
                .wb0_idx (wb0_idx),
                .wb0_dat (wb0_dat),
                .wb1_en  (wb1_en),
                .wb1_idx (wb1_idx),
                .wb1_dat (wb1_dat),
                .iss_en  (iss_en),
                .iss_idx (iss_idx),
`endif
                .dat     (rd_dat[k*DW +: DW]),
                .busy    (rd_busy[k])
            );
        end
    endgenerate

    // Any outstanding producer anywhere in the file.
    assign any_busy = |pend_q;
endmodule
